// File: rtl/axi_lite_sram_bridge_pkg.sv
// Shared types and helpers for the AXI4-lite to SRAM bridge.
package axi_lite_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4
  } bridge_state_t;

  // Which side won the most recent read/write contention.
  typedef enum logic {
    RR_READ  = 1'b0,
    RR_WRITE = 1'b1
  } rr_grant_t;

  localparam int AW_SLOT_W = 32;
  localparam int W_SLOT_W  = 36;   // {wstrb, wdata}
  localparam int AR_SLOT_W = 32;

  // Byte address beyond the last SRAM word.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int mem_words);
    return {2'b00, addr} >= (34'(mem_words) << 2);
  endfunction

endpackage

// File: rtl/axi_lite_sram_bridge_hold_slot.sv
// One-entry holding register for an AXI channel: ready while empty,
// loads on handshake, emptied by clear once the transaction retires.
module axi_lite_sram_bridge_hold_slot
  import axi_lite_sram_bridge_pkg::*;
#(
  parameter int W = AW_SLOT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] load_data,
  input  logic         clear,
  output logic         full,
  output logic [W-1:0] data
);

  assign ready = !full;

  // Occupancy flag and payload capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (valid && ready) begin
      full <= 1'b1;
      data <= load_data;
    end
  end

endmodule

// File: rtl/axi_lite_sram_bridge.sv
// AXI4-lite slave that serves one transaction at a time from a single-port
// synchronous SRAM. Read/write contention alternates round-robin.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a complete write (AW+W) or a read (AR)
// ST_WRITE | one SRAM write strobe, suppressed when out of range
// ST_WRESP | bvalid held until bready
// ST_READ  | SRAM read strobe, then READ_LATENCY cycles waiting for data
// ST_RDATA | rvalid with registered rdata held until rready
module axi_lite_sram_bridge
  import axi_lite_sram_bridge_pkg::*;
#(
  parameter int  MEM_WORDS    = 32768,
  parameter int  READ_LATENCY = 1,
  localparam int ADDR_BITS    = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_axi_awvalid,
  output logic                 mem_axi_awready,
  input  logic [31:0]          mem_axi_awaddr,
  input  logic [2:0]           mem_axi_awprot,
  input  logic                 mem_axi_wvalid,
  output logic                 mem_axi_wready,
  input  logic [31:0]          mem_axi_wdata,
  input  logic [3:0]           mem_axi_wstrb,
  output logic                 mem_axi_bvalid,
  input  logic                 mem_axi_bready,
  input  logic                 mem_axi_arvalid,
  output logic                 mem_axi_arready,
  input  logic [31:0]          mem_axi_araddr,
  input  logic [2:0]           mem_axi_arprot,
  output logic                 mem_axi_rvalid,
  input  logic                 mem_axi_rready,
  output logic [31:0]          mem_axi_rdata,
  output logic                 sram_en,
  output logic [3:0]           sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata,
  output logic                 decode_err
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  bridge_state_t        state, state_nxt;
  rr_grant_t            rr_last, rr_last_nxt;
  logic [1:0]           lat_cnt, lat_cnt_nxt;
  logic                 rd_first, rd_first_nxt;
  logic                 rd_capture;
  logic                 aw_full, w_full, ar_full;
  logic                 aw_clear, w_clear, ar_clear;
  logic [AW_SLOT_W-1:0] aw_q;
  logic [W_SLOT_W-1:0]  w_q;
  logic [AR_SLOT_W-1:0] ar_q;
  logic                 wr_elig, rd_elig;
  logic                 aw_err, ar_err;
  logic                 unused_prot;

  assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

  axi_lite_sram_bridge_hold_slot #(.W(AW_SLOT_W)) u_aw_slot (
    .clk       (clk),
    .reset     (reset),
    .valid     (mem_axi_awvalid),
    .ready     (mem_axi_awready),
    .load_data (mem_axi_awaddr),
    .clear     (aw_clear),
    .full      (aw_full),
    .data      (aw_q)
  );

  axi_lite_sram_bridge_hold_slot #(.W(W_SLOT_W)) u_w_slot (
    .clk       (clk),
    .reset     (reset),
    .valid     (mem_axi_wvalid),
    .ready     (mem_axi_wready),
    .load_data ({mem_axi_wstrb, mem_axi_wdata}),
    .clear     (w_clear),
    .full      (w_full),
    .data      (w_q)
  );

  axi_lite_sram_bridge_hold_slot #(.W(AR_SLOT_W)) u_ar_slot (
    .clk       (clk),
    .reset     (reset),
    .valid     (mem_axi_arvalid),
    .ready     (mem_axi_arready),
    .load_data (mem_axi_araddr),
    .clear     (ar_clear),
    .full      (ar_full),
    .data      (ar_q)
  );

  // A handshake in this cycle counts as a filled slot so the SRAM access
  // can start on the very next cycle.
  assign wr_elig = (aw_full || (mem_axi_awvalid && mem_axi_awready)) &&
                   (w_full  || (mem_axi_wvalid  && mem_axi_wready));
  assign rd_elig = ar_full || (mem_axi_arvalid && mem_axi_arready);
  assign aw_err  = addr_out_of_range(aw_q, MEM_WORDS);
  assign ar_err  = addr_out_of_range(ar_q, MEM_WORDS);

  // State, arbitration bit, latency timer and read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rr_last       <= RR_WRITE;
      lat_cnt       <= 2'd0;
      rd_first      <= 1'b0;
      mem_axi_rdata <= 32'h0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_last_nxt;
      lat_cnt  <= lat_cnt_nxt;
      rd_first <= rd_first_nxt;
      if (rd_capture) mem_axi_rdata <= ar_err ? 32'h0 : sram_rdata;
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_nxt      = state;
    rr_last_nxt    = rr_last;
    lat_cnt_nxt    = lat_cnt;
    rd_first_nxt   = rd_first;
    rd_capture     = 1'b0;
    sram_en        = 1'b0;
    sram_we        = 4'h0;
    sram_addr      = aw_q[ADDR_BITS+1:2];
    sram_wdata     = w_q[31:0];
    decode_err     = 1'b0;
    mem_axi_bvalid = 1'b0;
    mem_axi_rvalid = 1'b0;
    aw_clear       = 1'b0;
    w_clear        = 1'b0;
    ar_clear       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_elig && rd_elig) begin
          if (rr_last == RR_WRITE) begin
            state_nxt    = ST_READ;
            rr_last_nxt  = RR_READ;
            lat_cnt_nxt  = LAT_LOAD;
            rd_first_nxt = 1'b1;
          end else begin
            state_nxt   = ST_WRITE;
            rr_last_nxt = RR_WRITE;
          end
        end else if (wr_elig) begin
          state_nxt = ST_WRITE;
        end else if (rd_elig) begin
          state_nxt    = ST_READ;
          lat_cnt_nxt  = LAT_LOAD;
          rd_first_nxt = 1'b1;
        end
      end
      ST_WRITE: begin
        sram_en    = !aw_err;
        sram_we    = aw_err ? 4'h0 : w_q[35:32];
        decode_err = aw_err;
        state_nxt  = ST_WRESP;
      end
      ST_WRESP: begin
        mem_axi_bvalid = 1'b1;
        if (mem_axi_bready) begin
          aw_clear  = 1'b1;
          w_clear   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        sram_addr = ar_q[ADDR_BITS+1:2];
        if (rd_first) begin
          sram_en      = !ar_err;
          decode_err   = ar_err;
          rd_first_nxt = 1'b0;
        end else if (lat_cnt == 2'd0) begin
          rd_capture = 1'b1;
          state_nxt  = ST_RDATA;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
        end
      end
      ST_RDATA: begin
        mem_axi_rvalid = 1'b1;
        if (mem_axi_rready) begin
          ar_clear  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_sram_bridge.sv
// Directed bench for axi_lite_sram_bridge. Each transaction task writes the
// expected per-cycle outputs into timeline arrays using the protocol latencies;
// a negedge process compares the DUT against those arrays every cycle.
module tb_axi_lite_sram_bridge;
  localparam int RL        = 1;
  localparam int MEM_WORDS = 32768;
  localparam int NC        = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        sram_en, decode_err;
  logic [3:0]  sram_we;
  logic [14:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  axi_lite_sram_bridge #(.MEM_WORDS(MEM_WORDS), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
    .mem_axi_bready(bready), .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid),
    .mem_axi_rready(rready), .mem_axi_rdata(rdata), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .decode_err(decode_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous SRAM with READ_LATENCY pipeline; junk when no read data is due.
  logic [31:0] sram_mem [0:MEM_WORDS-1];
  logic [31:0] rd_pipe  [1:4];
  logic        rd_v     [1:4];
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) sram_mem[i] = 32'h0;
    for (int i = 1; i <= 4; i++) begin rd_v[i] = 1'b0; rd_pipe[i] = 32'h0; end
  end
  always @(posedge clk) begin
    rd_v[1]    <= sram_en && (sram_we == 4'h0);
    rd_pipe[1] <= sram_mem[sram_addr];
    for (int i = 2; i <= 4; i++) begin
      rd_v[i]    <= rd_v[i-1];
      rd_pipe[i] <= rd_pipe[i-1];
    end
    if (sram_en && sram_we != 4'h0)
      sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_we);
  end
  assign sram_rdata = rd_v[RL] ? rd_pipe[RL] : 32'hBAD0_BAD0;

  // Reference memory at the AXI level and expected-output timeline.
  logic [31:0] ref_mem [int];
  bit          x_awbusy [NC];
  bit          x_wbusy  [NC];
  bit          x_arbusy [NC];
  bit          x_bvalid [NC];
  bit          x_rvalid [NC];
  bit          x_en     [NC];
  bit          x_err    [NC];
  logic [3:0]  x_we     [NC];
  logic [14:0] x_addr   [NC];
  logic [31:0] x_wdata  [NC];
  logic [31:0] x_rdata  [NC];
  bit          rr_read_next = 1'b1;
  bit          chk_on = 1'b0;

  function automatic bit oor(input logic [31:0] a);
    return a >= 32'(4 * MEM_WORDS);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  // n: last handshake / decision cycle, nb: B handshake (or reset) cycle.
  function automatic void exp_write(int n, int t_aw, int t_w, int nb,
                                    logic [31:0] a, logic [31:0] d, logic [3:0] s);
    for (int c = t_aw + 1; c <= nb; c++) x_awbusy[c] = 1'b1;
    for (int c = t_w + 1; c <= nb; c++)  x_wbusy[c]  = 1'b1;
    if (oor(a)) x_err[n+1] = 1'b1;
    else begin
      x_en[n+1] = 1'b1; x_we[n+1] = s; x_addr[n+1] = a[16:2]; x_wdata[n+1] = d;
      ref_mem[int'(a >> 2)] = merge(ref_rd(a), d, s);
    end
    for (int c = n + 2; c <= nb; c++) x_bvalid[c] = 1'b1;
  endfunction

  function automatic void exp_read(int n, int t_ar, int nr, logic [31:0] a);
    logic [31:0] v;
    v = oor(a) ? 32'h0 : ref_rd(a);
    for (int c = t_ar + 1; c <= nr; c++) x_arbusy[c] = 1'b1;
    if (oor(a)) x_err[n+1] = 1'b1;
    else begin x_en[n+1] = 1'b1; x_we[n+1] = 4'h0; x_addr[n+1] = a[16:2]; end
    for (int c = n + 2 + RL; c <= nr; c++) begin x_rvalid[c] = 1'b1; x_rdata[c] = v; end
  endfunction

  // Per-cycle compare against the timeline.
  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      chk("awready", awready, !x_awbusy[cyc]);
      chk("wready", wready, !x_wbusy[cyc]);
      chk("arready", arready, !x_arbusy[cyc]);
      chk("bvalid", bvalid, x_bvalid[cyc]);
      chk("rvalid", rvalid, x_rvalid[cyc]);
      chk("sram_en", sram_en, x_en[cyc]);
      chk("decode_err", decode_err, x_err[cyc]);
      if (!x_en[cyc]) chk("sram_we_idle", sram_we, 4'h0);
      if (x_en[cyc]) begin
        chk("sram_we", sram_we, x_we[cyc]);
        chk("sram_addr", sram_addr, x_addr[cyc]);
        if (x_we[cyc] != 4'h0) chk("sram_wdata", sram_wdata, x_wdata[cyc]);
      end
      if (x_rvalid[cyc]) chk("rdata", rdata, x_rdata[cyc]);
    end
  end

  // Observations used by the hand-computed literal checks.
  int          en_count = 0, err_count = 0, last_en_cyc = 0, b_rise = 0, r_rise = 0;
  logic [14:0] last_en_addr = '0;
  logic [3:0]  last_en_we = '0;
  logic [31:0] last_rdata = '0;
  logic        prev_b = 1'b0, prev_r = 1'b0;
  always @(negedge clk) begin
    if (sram_en) begin
      en_count     <= en_count + 1;
      last_en_cyc  <= cyc;
      last_en_addr <= sram_addr;
      last_en_we   <= sram_we;
    end
    if (decode_err) err_count <= err_count + 1;
    if (bvalid && !prev_b) b_rise <= cyc;
    if (rvalid && !prev_r) r_rise <= cyc;
    if (rvalid) last_rdata <= rdata;
    prev_b <= bvalid;
    prev_r <= rvalid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; reset = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    rr_read_next = 1'b1;
  endtask

  // W issued now, AW w_lead cycles later; bready after bstall, or reset at rst_off.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, input int bstall, input int rst_off);
    int t0, n, nb;
    bit use_rst;
    t0 = cyc; n = t0 + w_lead; use_rst = (rst_off >= 0);
    nb = n + 2 + (use_rst ? rst_off : bstall);
    exp_write(n, n, t0, nb, a, d, s);
    for (int c = t0; c <= nb; c++) begin
      wvalid = (c == t0); wdata = d; wstrb = s;
      awvalid = (c == n); awaddr = a;
      bready = !use_rst && (c == nb);
      reset = use_rst && (c == nb);
      tick();
    end
    clear_inputs();
    if (use_rst) rr_read_next = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a, input int rstall, input int rst_off);
    int t0, nr;
    bit use_rst;
    t0 = cyc; use_rst = (rst_off >= 0);
    nr = t0 + 2 + RL + (use_rst ? rst_off : rstall);
    exp_read(t0, t0, nr, a);
    for (int c = t0; c <= nr; c++) begin
      arvalid = (c == t0); araddr = a;
      rready = !use_rst && (c == nr);
      reset = use_rst && (c == nr);
      tick();
    end
    clear_inputs();
    if (use_rst) rr_read_next = 1'b1;
  endtask

  // AW, W and AR all presented in the same cycle; each response taken at once.
  task automatic contend(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] ra);
    int t0, nr, nb, last;
    t0 = cyc;
    if (rr_read_next) begin
      nr = t0 + 2 + RL;
      nb = nr + 3;
      exp_read(t0, t0, nr, ra);
      exp_write(nr + 1, t0, t0, nb, wa, d, s);
      last = nb;
    end else begin
      nb = t0 + 2;
      nr = nb + 3 + RL;
      exp_write(t0, t0, t0, nb, wa, d, s);
      exp_read(nb + 1, t0, nr, ra);
      last = nr;
    end
    rr_read_next = !rr_read_next;
    for (int c = t0; c <= last; c++) begin
      awvalid = (c == t0); wvalid = (c == t0); arvalid = (c == t0);
      awaddr = wa; wdata = d; wstrb = s; araddr = ra;
      bready = (c == nb); rready = (c == nr);
      tick();
    end
    clear_inputs();
  endtask

  int t, e0, er0;

  initial begin
    awprot = 3'h0; arprot = 3'h0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    chk_on = 1'b1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bvalid", bvalid, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // AW+W together
    t = cyc;
    wr(32'h100, 32'hDEAD_BEEF, 4'hF, 0, 0, -1);
    chk("t1_en_addr", last_en_addr, 15'h40);
    chk("t1_en_we", last_en_we, 4'hF);
    chk("t1_en_cyc", last_en_cyc - t, 1);
    chk("t1_b_lat", b_rise - t, 2);

    // W first, AW three cycles later; then a partial-strobe overwrite
    t = cyc;
    wr(32'h104, 32'h1122_3344, 4'hF, 3, 0, -1);
    chk("t2_en_cyc", last_en_cyc - t, 4);
    chk("t2_b_lat", b_rise - t, 5);
    wr(32'h104, 32'hAABB_CCDD, 4'h5, 0, 2, -1);

    // Reads with an rready stall
    t = cyc;
    rd(32'h100, 5, -1);
    chk("t3_r_lat", r_rise - t, 3);
    chk("t3_rdata", last_rdata, 32'hDEAD_BEEF);
    rd(32'h104, 0, -1);
    chk("t3_strb_rdata", last_rdata, 32'h11BB_33DD);

    // Contention: read, then write, then read wins
    do_reset();
    tick();
    contend(32'h200, 32'hCAFE_F00D, 4'hF, 32'h100);
    chk("t4_read_first", last_rdata, 32'hDEAD_BEEF);
    contend(32'h100, 32'h0102_0304, 4'hF, 32'h100);
    chk("t4_write_first", last_rdata, 32'h0102_0304);
    contend(32'h200, 32'h55AA_55AA, 4'hF, 32'h200);
    chk("t4_read_again", last_rdata, 32'hCAFE_F00D);

    // Out-of-range and last in-range word
    e0 = en_count; er0 = err_count;
    wr(32'h0002_0000, 32'h1234_5678, 4'hF, 0, 1, -1);
    rd(32'h0002_0000, 0, -1);
    chk("t5_no_en", en_count - e0, 0);
    chk("t5_err_pulses", err_count - er0, 2);
    chk("t5_rdata", last_rdata, 32'h0);
    wr(32'h0001_FFFC, 32'h7777_8888, 4'hF, 0, 0, -1);
    chk("t5_top_addr", last_en_addr, 15'h7FFF);
    rd(32'h0001_FFFC, 0, -1);
    chk("t5_top_rdata", last_rdata, 32'h7777_8888);

    // Reset during RDATA and during WRESP, then a fresh read
    rd(32'h0001_FFFC, 3, 1);
    chk("t6_rst_rdata", rdata, 32'h0);
    chk("t6_rst_rvalid", rvalid, 1'b0);
    chk("t6_rst_arready", arready, 1'b1);
    wr(32'h300, 32'h9999_0000, 4'hF, 0, 4, 2);
    chk("t6_rst_bvalid", bvalid, 1'b0);
    chk("t6_rst_awready", awready, 1'b1);
    chk("t6_rst_wready", wready, 1'b1);
    t = cyc;
    rd(32'h100, 1, -1);
    chk("t6_fresh_lat", r_rise - t, 3);
    chk("t6_fresh_rdata", last_rdata, 32'h0102_0304);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
